// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
// Holds the arbiter state encoding, the width helpers and the packed data slice.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_NUM_REQ_DEF   = 4;
  localparam int ARB_MAX_BURST_DEF = 4;

  function automatic int idWidth(input int numReq);
    return $clog2(numReq);
  endfunction

  function automatic int cntWidth(input int maxBurst);
    return $clog2(maxBurst + 1);
  endfunction

  localparam int ARB_ID_W  = idWidth(ARB_NUM_REQ_DEF);
  localparam int ARB_CNT_W = cntWidth(ARB_MAX_BURST_DEF);

  // Requester i owns bits [i*width +: width] of the packed data bus.
  function automatic int dataLsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Round-robin search: first set request bit after start, wrapping around.
// With mask_i set, the start position itself is never chosen.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ_DEF,
  parameter int ID_W    = ARB_ID_W
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    start_i,
  input  logic               mask_i,
  output logic               found_o,
  output logic [ID_W-1:0]    idx_o
);

  // Start is visited last, so its priority is lowest in the rotation.
  always_comb begin
    int cand;
    logic [ID_W-1:0] candIdx;
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    candIdx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand    = (int'(start_i) + k) % NUM_REQ;
      candIdx = ID_W'(cand);
      if (!found_o && req_i[candIdx] && !(mask_i && (k == NUM_REQ))) begin
        found_o = 1'b1;
        idx_o   = candIdx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NUM_REQ producers,
// with a bounded burst quantum per grant and back-pressure on FIFO full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int NUM_REQ   = ARB_NUM_REQ_DEF,
  parameter int MAX_BURST = ARB_MAX_BURST_DEF,
  localparam int ID_W     = idWidth(NUM_REQ),
  localparam int CNT_W    = cntWidth(MAX_BURST)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_push,
  output logic [WIDTH-1:0]         fifo_data,
  output logic                     grant_active,
  output logic [ID_W-1:0]          grant_id
);

  if (NUM_REQ < 2 || MAX_BURST < 1 || DEPTH < 1) begin : g_bad_params
    $error("fifo_wr_arbiter: NUM_REQ>=2, MAX_BURST>=1 and DEPTH>=1 required");
  end

  arb_state_t       state_q,    state_d;
  logic [ID_W-1:0]  grantId_q,  grantId_d;
  logic [ID_W-1:0]  lastId_q,   lastId_d;
  logic [CNT_W-1:0] burstCnt_q, burstCnt_d;

  logic            pickAFound, pickBFound;
  logic [ID_W-1:0] pickAIdx,   pickBIdx;
  logic [ID_W-1:0] pickAStart;
  logic            grantValid;

  // Entry from IDLE rotates from the last grantee; quantum exit from the current one.
  assign pickAStart = (state_q == IDLE) ? lastId_q : grantId_q;
  assign grantValid = req_valid[grantId_q];

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick_next (
    .req_i   (req_valid),
    .start_i (pickAStart),
    .mask_i  (1'b0),
    .found_o (pickAFound),
    .idx_o   (pickAIdx)
  );

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick_withdraw (
    .req_i   (req_valid),
    .start_i (grantId_q),
    .mask_i  (1'b1),
    .found_o (pickBFound),
    .idx_o   (pickBIdx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      grantId_q  <= '0;
      lastId_q   <= ID_W'(NUM_REQ - 1);
      burstCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grantId_q  <= grantId_d;
      lastId_q   <= lastId_d;
      burstCnt_q <= burstCnt_d;
    end
  end

  // While reset is held the handshake is suppressed so a pending word stays with its producer.
  always_comb begin
    state_d      = state_q;
    grantId_d    = grantId_q;
    lastId_d     = lastId_q;
    burstCnt_d   = burstCnt_q;
    req_ready    = '0;
    fifo_push    = 1'b0;
    fifo_data    = '0;
    grant_active = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pickAFound) begin
          state_d    = GRANT;
          grantId_d  = pickAIdx;
          burstCnt_d = '0;
        end
      end

      GRANT: begin
        grant_active         = 1'b1;
        req_ready[grantId_q] = ~fifo_full & rst;
        fifo_push            = grantValid & ~fifo_full & rst;
        fifo_data            = req_data[dataLsb(int'(grantId_q), WIDTH) +: WIDTH];

        if (!grantValid) begin
          lastId_d   = grantId_q;
          burstCnt_d = '0;
          if (pickBFound) begin
            grantId_d = pickBIdx;
          end else begin
            state_d = IDLE;
          end
        end else if (fifo_push) begin
          if (burstCnt_q == CNT_W'(MAX_BURST - 1)) begin
            lastId_d   = grantId_q;
            burstCnt_d = '0;
            if (pickAFound) begin
              grantId_d = pickAIdx;
            end else begin
              state_d = IDLE;
            end
          end else begin
            burstCnt_d = burstCnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign grant_id = grantId_q;

  a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(req_ready));
  a_push_not_full : assert property (@(posedge clk) disable iff (!rst) fifo_push |-> !fifo_full);
  a_push_granted  : assert property (@(posedge clk) disable iff (!rst) fifo_push |-> grant_active);
  a_burst_bound   : assert property (@(posedge clk) disable iff (!rst) burstCnt_q < CNT_W'(MAX_BURST));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: one task per scenario with inline checks.
// Each producer i sends {i, wordIdx[i]} and advances only on an accepted word.
module tb_fifo_wr_arbiter;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 32;
  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 4;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_push;
  logic [WIDTH-1:0]         fifo_data;
  logic                     grant_active;
  logic [1:0]               grant_id;

  logic [3:0] wordIdx [NUM_REQ];
  int total;
  int bad;

  fifo_wr_arbiter #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_push    (fifo_push),
    .fifo_data    (fifo_data),
    .grant_active (grant_active),
    .grant_id     (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[i*WIDTH +: WIDTH] = {4'(i), wordIdx[i]};
    end
  end

  // Record handshakes seen before the edge, then step producers past the edge.
  task automatic tick();
    logic [NUM_REQ-1:0] acc;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) wordIdx[i] = wordIdx[i] + 4'd1;
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic doReset();
    req_valid = '0;
    fifo_full = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) wordIdx[i] = 4'd0;
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    fifo_full = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) wordIdx[i] = 4'd0;
    for (int e = 0; e < 2; e++) begin
      tick();
      settle();
      total++;
      if (fifo_push !== 1'b0 || req_ready !== 4'b0000 || grant_active !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_idle edge%0d: push=%b ready=%b active=%b, want 0/0000/0", e, fifo_push, req_ready, grant_active);
      end
    end
    rst = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      settle();
      total++;
      if (grant_active !== 1'b1 || grant_id !== 2'd0 || fifo_push !== 1'b1 || fifo_data !== {4'h0, 4'(k)}) begin
        bad++;
        $display("[TB] FAIL reset_first_burst k=%0d: active=%b id=%0d push=%b data=%h, want 1/0/1/%h", k, grant_active, grant_id, fifo_push, fifo_data, {4'h0, 4'(k)});
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int pushes;
    logic [1:0] expG;
    logic [7:0] expD;
    pushes = 0;
    for (int c = 0; c < 16; c++) begin
      settle();
      expG = 2'((c / 4 + 1) % 4);
      expD = {2'b00, expG, 4'((c % 4) + ((expG == 2'd0) ? 4 : 0))};
      if (fifo_push === 1'b1) pushes++;
      total++;
      if (grant_id !== expG || fifo_push !== 1'b1 || fifo_data !== expD || req_ready !== (4'b0001 << expG)) begin
        bad++;
        $display("[TB] FAIL round_robin c=%0d: id=%0d push=%b data=%h ready=%b, want %0d/1/%h/%b", c, grant_id, fifo_push, fifo_data, req_ready, expG, expD, 4'b0001 << expG);
      end
      tick();
    end
    total++;
    if (pushes !== 16) begin
      bad++;
      $display("[TB] FAIL round_robin_count: pushes=%0d, want 16", pushes);
    end
  endtask

  task automatic test_single_requester();
    doReset();
    req_valid = 4'b0100;
    settle();
    total++;
    if (fifo_push !== 1'b0 || grant_active !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_bubble: push=%b active=%b, want 0/0", fifo_push, grant_active);
    end
    tick();
    for (int k = 0; k < 12; k++) begin
      settle();
      total++;
      if (grant_id !== 2'd2 || fifo_push !== 1'b1 || fifo_data !== {4'h2, 4'(k)} || dut.burstCnt_q !== 3'(k % 4)) begin
        bad++;
        $display("[TB] FAIL single_stream k=%0d: id=%0d push=%b data=%h burst=%0d, want 2/1/%h/%0d", k, grant_id, fifo_push, fifo_data, dut.burstCnt_q, {4'h2, 4'(k)}, k % 4);
      end
      tick();
    end
  endtask

  task automatic test_full_stall();
    doReset();
    req_valid = 4'b0110;
    tick();
    for (int k = 0; k < 2; k++) begin
      settle();
      total++;
      if (grant_id !== 2'd1 || fifo_push !== 1'b1 || fifo_data !== {4'h1, 4'(k)}) begin
        bad++;
        $display("[TB] FAIL stall_pre k=%0d: id=%0d push=%b data=%h, want 1/1/%h", k, grant_id, fifo_push, fifo_data, {4'h1, 4'(k)});
      end
      tick();
    end
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      total++;
      if (grant_id !== 2'd1 || fifo_push !== 1'b0 || req_ready !== 4'b0000 || grant_active !== 1'b1) begin
        bad++;
        $display("[TB] FAIL stall_hold k=%0d: id=%0d push=%b ready=%b active=%b, want 1/0/0000/1", k, grant_id, fifo_push, req_ready, grant_active);
      end
      tick();
    end
    fifo_full = 1'b0;
    for (int k = 2; k < 4; k++) begin
      settle();
      total++;
      if (grant_id !== 2'd1 || fifo_push !== 1'b1 || fifo_data !== {4'h1, 4'(k)}) begin
        bad++;
        $display("[TB] FAIL stall_post k=%0d: id=%0d push=%b data=%h, want 1/1/%h", k, grant_id, fifo_push, fifo_data, {4'h1, 4'(k)});
      end
      tick();
    end
    settle();
    total++;
    if (grant_id !== 2'd2 || fifo_push !== 1'b1 || fifo_data !== 8'h20) begin
      bad++;
      $display("[TB] FAIL stall_rotate: id=%0d push=%b data=%h, want 2/1/20", grant_id, fifo_push, fifo_data);
    end
  endtask

  task automatic test_withdraw();
    doReset();
    req_valid = 4'b1001;
    tick();
    settle();
    total++;
    if (grant_id !== 2'd0 || fifo_push !== 1'b1 || fifo_data !== 8'h00) begin
      bad++;
      $display("[TB] FAIL withdraw_first: id=%0d push=%b data=%h, want 0/1/00", grant_id, fifo_push, fifo_data);
    end
    tick();
    req_valid = 4'b1000;
    settle();
    total++;
    if (fifo_push !== 1'b0 || grant_active !== 1'b1 || grant_id !== 2'd0) begin
      bad++;
      $display("[TB] FAIL withdraw_drop: push=%b active=%b id=%0d, want 0/1/0", fifo_push, grant_active, grant_id);
    end
    tick();
    settle();
    total++;
    if (grant_id !== 2'd3 || grant_active !== 1'b1 || fifo_push !== 1'b1 || fifo_data !== 8'h30) begin
      bad++;
      $display("[TB] FAIL withdraw_next: id=%0d active=%b push=%b data=%h, want 3/1/1/30", grant_id, grant_active, fifo_push, fifo_data);
    end
  endtask

  task automatic test_reset_midburst();
    tick();
    settle();
    total++;
    if (grant_id !== 2'd3 || fifo_push !== 1'b1 || fifo_data !== 8'h31) begin
      bad++;
      $display("[TB] FAIL midburst_pre: id=%0d push=%b data=%h, want 3/1/31", grant_id, fifo_push, fifo_data);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req_valid = 4'b1001;
    settle();
    total++;
    if (fifo_push !== 1'b0 || grant_active !== 1'b0 || req_ready !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL midburst_idle: push=%b active=%b ready=%b, want 0/0/0000", fifo_push, grant_active, req_ready);
    end
    tick();
    settle();
    total++;
    if (grant_id !== 2'd0 || grant_active !== 1'b1 || fifo_push !== 1'b1 || fifo_data !== 8'h01) begin
      bad++;
      $display("[TB] FAIL midburst_regrant: id=%0d active=%b push=%b data=%h, want 0/1/1/01", grant_id, grant_active, fifo_push, fifo_data);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) wordIdx[i] = 4'd0;
    test_reset();
    test_round_robin();
    test_single_requester();
    test_full_stall();
    test_withdraw();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the single write port of the FIFO block between NUM_REQ independent producers. It grants one requester at a time, holding the grant for a bounded burst quantum. It drives the FIFO push and data directly and back-pressures producers whenever the FIFO reports full. The block sits between the producer side of the datapath and the FIFO write side of the FIFO bus interface.

Parameters:
WIDTH, 8, data word width; matches the FIFO WIDTH.
DEPTH, 32, FIFO depth; informational only, must match the FIFO instance.
NUM_REQ, 4, number of requesters; must be at least 2.
MAX_BURST, 4, maximum consecutive transfers per grant; must be at least 1.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous active-low reset: sampled on the rising edge of clk, 0 = reset.
req_valid  in  NUM_REQ  per-requester write request.
req_data  in  NUM_REQ*WIDTH  packed request data; requester i occupies bits [i*WIDTH +: WIDTH].
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
fifo_full  in  1  FIFO full flag.
fifo_push  out  1  FIFO write enable.
fifo_data  out  WIDTH  FIFO write data.
grant_active  out  1  high while in state GRANT.
grant_id  out  $clog2(NUM_REQ)  index of the current grantee.

Behaviour:
- Registers: state (IDLE/GRANT), grant_id, last_id, burst_cnt ($clog2(MAX_BURST+1) bits).
- Reset (rising edge with rst=0): state=IDLE, grant_id=0, last_id=NUM_REQ-1, burst_cnt=0. Requester 0 therefore has first priority.
- Outputs are combinational from state and inputs:
  - In IDLE: fifo_push=0, req_ready=0, fifo_data=0, grant_active=0.
  - In GRANT with g=grant_id: req_ready[g]=~fifo_full, fifo_push=req_valid[g]&~fifo_full, fifo_data=req_data[g]. All other req_ready bits are 0.
- Transfer: a cycle with fifo_push=1. Zero latency from valid to push.
- Producer rule: once req_valid is asserted, it stays high with stable data until accepted. Dropping valid without a transfer is legal and means withdrawal.
- Pick function: the first set bit of req_valid searched from (start+1) mod NUM_REQ upward with wrap-around. The requester at start itself is checked last.
- IDLE:
  - If any req_valid: next state GRANT, grant_id=pick(last_id), burst_cnt=0.
  - Otherwise stay in IDLE.
  - No transfer happens in the IDLE cycle, so there is a 1-cycle bubble after IDLE.
- GRANT, exit conditions:
  - (a) Transfer with burst_cnt==MAX_BURST-1 (quantum exhausted).
  - (b) req_valid[g]=0 (withdrawal or stream end); no transfer happens in that cycle.
- GRANT, on exit: last_id<=g, burst_cnt<=0.
  - On (a), use the pick over the current req_valid from start g.
  - On (b), use the pick over the current req_valid with bit g masked.
  - If a pick exists: stay in GRANT with the new grant_id, with no bubble.
  - Otherwise go to IDLE.
  - Under (a), g itself may be re-granted if it is the only valid requester.
- GRANT, no exit: burst_cnt increments on transfer and holds otherwise.
- fifo_full=1 stalls: no push, no ready. grant_id and burst_cnt hold and no rotation occurs, however long full persists.
- MAX_BURST=1 gives pure per-word round-robin.
- Reset mid-burst discards the grant; the pending word stays with its producer (valid remains high) and nothing is pushed.
- Throughput: with continuous requests and fifo_full=0, one push per cycle except the bubble after IDLE.
- Assertions:
  - req_ready is onehot0.
  - fifo_push implies fifo_full==0.
  - fifo_push implies grant_active.
  - burst_cnt<MAX_BURST.

Decomposition:
- Package fifo_arb_pkg holds:
  - the arb_state_t enum {IDLE, GRANT};
  - the localparams for the grant_id and burst_cnt widths;
  - a function/helper for the packed data slice.
- One combinational sub-module, fifo_rr_pick: inputs are the req vector, the start index and a mask enable; outputs are found and idx.
- It is instantiated twice: once for entry from IDLE and exit (a), once for exit (b).

Test Plan:
All scenarios use NUM_REQ=4, MAX_BURST=4, WIDTH=8, DEPTH=32, with requester i sending data 8'h{i}0 incrementing.
- Reset: rst=0 for 2 edges, all req_valid=1 -> fifo_push=0, req_ready=0, grant_active=0. On the first edge with rst=1 the arbiter enters GRANT with grant_id=0; pushes 8'h00..8'h03 follow.
- All four valid continuously, fifo_full=0 -> grant order 0,1,2,3,0. Exactly 4 pushes per grant, 16 pushes in 16 consecutive cycles, no bubbles.
- Only requester 2 valid continuously -> grant_id stays 2. After every 4 pushes burst_cnt returns to 0; push never deasserts.
- Grant to requester 1 after 2 pushes, fifo_full=1 for 5 cycles -> 5 cycles with push=0 and req_ready=0 while grant_id stays 1. Then 2 more pushes (8'h12, 8'h13), then the grant moves to 2.
- Requester 0 drops valid after 1 push while 3 is valid -> no push in the drop cycle. Next cycle grant_id=3, with no IDLE visit.
- rst=0 asserted mid-burst of requester 3 -> next cycle push=0 and state IDLE. After release, requester 0 is granted first.
